var_delay_line: RTL



---
 rtl/var_delay_line_pkg.sv | 28 ++
 rtl/var_delay_line_ram.sv | 28 ++
 rtl/var_delay_line.sv | 82 ++++++++
 3 files changed

// File: rtl/var_delay_line_pkg.sv
// Shared constants and helpers for the FMCW sample buffers.
package var_delay_line_pkg;

   // Fill/valid progress of a delay line since the last reset or load
   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_VALID   = 2'd2
   } fill_state_t;

   // Address width able to hold every delay 0..max_len
   function automatic int unsigned calc_aw(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

   // Map a requested delay onto the legal range 1..max_len
   function automatic int unsigned clamp_len(input int unsigned req,
                                             input int unsigned max_len);
      if (req == 0) begin
         return 1;
      end
      if (req > max_len) begin
         return max_len;
      end
      return req;
   endfunction

endpackage

// File: rtl/var_delay_line_ram.sv
// Simple dual-port RAM, one write port and one registered read port on clk.
module var_delay_line_ram #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SIZE  = 16,
   localparam int unsigned AW   = $clog2(SIZE)
) (
   input  logic             clk,
   input  logic             wren,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rden,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [SIZE];

   // Write port and registered read port
   always_ff @(posedge clk) begin
      if (wren) begin
         mem[waddr] <= wdata;
      end
      if (rden) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/var_delay_line.sv
// Runtime-programmable RAM-backed sample delay line with primed-output masking.
module var_delay_line
   import var_delay_line_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 25,
   parameter int unsigned MAX_LEN     = 512,
   parameter int unsigned DEFAULT_LEN = 512
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             ce,
   input  logic [DATA_WIDTH-1:0]            di,
   input  logic [calc_aw(MAX_LEN)-1:0]      len_i,
   input  logic                             len_ld,
   output logic [calc_aw(MAX_LEN)-1:0]      len_o,
   output logic                             valid_o,
   output logic [DATA_WIDTH-1:0]            data_o
);

   localparam int unsigned AW    = calc_aw(MAX_LEN);
   localparam int unsigned DEPTH = 32'(1) << AW;

   logic [AW-1:0]         wptr_q;
   logic [AW-1:0]         fill_q;
   logic [AW-1:0]         len_q;
   logic                  valid_q;
   fill_state_t           state_q;
   logic                  ram_en;
   logic [AW-1:0]         raddr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // RAM ports are idle on load cycles so the dropped sample never lands
   assign ram_en = ce & ~len_ld;
   assign raddr  = wptr_q - len_q;

   var_delay_line_ram #(
      .WIDTH (DATA_WIDTH),
      .SIZE  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .wren  (ram_en),
      .waddr (wptr_q),
      .wdata (di),
      .rden  (ram_en),
      .raddr (raddr),
      .rdata (ram_rdata)
   );

   // Pointer, active delay and EMPTY->FILLING->VALID progress
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         fill_q  <= '0;
         len_q   <= AW'(DEFAULT_LEN);
         valid_q <= 1'b0;
         state_q <= ST_EMPTY;
      end else if (len_ld) begin
         wptr_q  <= '0;
         fill_q  <= '0;
         len_q   <= AW'(clamp_len(32'(len_i), MAX_LEN));
         valid_q <= 1'b0;
         state_q <= ST_EMPTY;
      end else if (ce) begin
         wptr_q <= wptr_q + AW'(1);
         if (state_q != ST_VALID) begin
            if (fill_q == len_q) begin
               valid_q <= 1'b1;
               state_q <= ST_VALID;
            end else begin
               fill_q  <= fill_q + AW'(1);
               state_q <= ST_FILLING;
            end
         end
      end
   end

   assign len_o   = len_q;
   assign valid_o = valid_q;
   // Stale RAM contents never reach the output before the line is primed
   assign data_o  = valid_q ? ram_rdata : '0;

endmodule
